// File: rtl/tx_message_arbiter.sv
// TX message arbiter: picks the next frame from the high-priority buffer
// (preferred) or the TX FIFO, presents it to the bit-stream transmitter,
// and retries on error or lost arbitration until it succeeds, the retry
// limit is reached, or software aborts it.
module tx_message_arbiter #(
  parameter int MAX_RETRY = 8
) (
  input  logic         i_sys_clk,
  input  logic         i_reset,
  input  logic         i_txfifo_empty,
  output logic         o_txfifo_r_en,
  input  logic [127:0] i_txfifo_r_data,
  input  logic         i_txhpb_valid,
  input  logic [127:0] i_txhpb_data,
  output logic         o_txhpb_clr,
  output logic [127:0] o_tx_message,
  output logic         o_tx_req,
  input  logic         i_tx_done,
  input  logic         i_tx_arb_lost,
  input  logic         i_tx_error,
  input  logic         i_abort,
  output logic         o_txbsy,
  output logic         o_tx_ok,
  output logic         o_tx_fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_REQUEST, S_BACKOFF, S_COMPLETE, S_DROP
  } state_t;

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  state_t     r_state;
  logic       r_src_hpb;
  logic [3:0] r_retry;

  // Error and lost arbitration in the same cycle cost a single attempt.
  logic       w_fail_evt;
  logic [3:0] w_retry_inc;

  assign w_fail_evt  = i_tx_error | i_tx_arb_lost;
  // Saturating increment so the counter can never wrap back to zero.
  assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

  // Single FSM; every output is registered as a function of the state being entered.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_src_hpb     <= 1'b0;
      r_retry       <= 4'd0;
      o_tx_message  <= 128'd0;
      o_txfifo_r_en <= 1'b0;
      o_txhpb_clr   <= 1'b0;
      o_tx_req      <= 1'b0;
      o_txbsy       <= 1'b0;
      o_tx_ok       <= 1'b0;
      o_tx_fail     <= 1'b0;
    end else begin
      o_txfifo_r_en <= 1'b0;
      o_txhpb_clr   <= 1'b0;
      o_tx_ok       <= 1'b0;
      o_tx_fail     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_txhpb_valid) begin
            r_state   <= S_FETCH;
            r_src_hpb <= 1'b1;
            o_txbsy   <= 1'b1;
          end else if (!i_txfifo_empty) begin
            // Pop lands in FETCH; data is on the bus during LATCH.
            r_state       <= S_FETCH;
            r_src_hpb     <= 1'b0;
            o_txfifo_r_en <= 1'b1;
            o_txbsy       <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          o_tx_message <= r_src_hpb ? i_txhpb_data : i_txfifo_r_data;
          r_retry      <= 4'd0;
          r_state      <= S_REQUEST;
          o_tx_req     <= 1'b1;
        end
        S_REQUEST: begin
          // Done beats any failure event, and any event beats abort.
          if (i_tx_done) begin
            r_state     <= S_COMPLETE;
            o_tx_req    <= 1'b0;
            o_tx_ok     <= 1'b1;
            o_txhpb_clr <= r_src_hpb;
          end else if (w_fail_evt) begin
            r_retry  <= w_retry_inc;
            o_tx_req <= 1'b0;
            if (w_retry_inc == MAX_RETRY_C) begin
              r_state     <= S_DROP;
              o_tx_fail   <= 1'b1;
              o_txhpb_clr <= r_src_hpb;
            end else begin
              r_state <= S_BACKOFF;
            end
          end else if (i_abort) begin
            r_state     <= S_DROP;
            o_tx_req    <= 1'b0;
            o_tx_fail   <= 1'b1;
            o_txhpb_clr <= r_src_hpb;
          end
        end
        S_BACKOFF: begin
          if (i_abort) begin
            r_state     <= S_DROP;
            o_tx_fail   <= 1'b1;
            o_txhpb_clr <= r_src_hpb;
          end else begin
            r_state  <= S_REQUEST;
            o_tx_req <= 1'b1;
          end
        end
        S_COMPLETE, S_DROP: begin
          r_state <= S_IDLE;
          o_txbsy <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          o_tx_req <= 1'b0;
          o_txbsy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_message_arbiter.sv
// Randomized scoreboard bench for tx_message_arbiter: FIFO/HPB source models,
// a randomized transmitter responder, and an independent end-of-message monitor.
module tb_tx_message_arbiter;
  localparam int MAX_RETRY = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_ren;
  logic [127:0] fifo_rdata;
  logic         hpb_valid;
  logic [127:0] hpb_data;
  logic         hpb_clr;
  logic [127:0] tx_msg;
  logic         tx_req;
  logic         tx_done, tx_arb, tx_err, abort_l;
  logic         txbsy, tx_ok, tx_fail;

  always #5 clk = ~clk;

  tx_message_arbiter #(.MAX_RETRY(MAX_RETRY)) dut (
    .i_sys_clk(clk), .i_reset(rst),
    .i_txfifo_empty(fifo_empty), .o_txfifo_r_en(fifo_ren), .i_txfifo_r_data(fifo_rdata),
    .i_txhpb_valid(hpb_valid), .i_txhpb_data(hpb_data), .o_txhpb_clr(hpb_clr),
    .o_tx_message(tx_msg), .o_tx_req(tx_req),
    .i_tx_done(tx_done), .i_tx_arb_lost(tx_arb), .i_tx_error(tx_err), .i_abort(abort_l),
    .o_txbsy(txbsy), .o_tx_ok(tx_ok), .o_tx_fail(tx_fail)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         hpb;
  } exp_t;

  exp_t         exp_q[$];   // messages in the order they must be sent
  bit           out_q[$];   // per-message outcome: 1 = ok, 0 = dropped
  logic [127:0] fifo_q[$];
  int errors = 0, checks = 0;
  int pops = 0, pushes = 0;
  bit resp_en = 1'b0;
  bit in_bo = 1'b0;
  int fails = 0;
  int rsel;
  bit fe;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // FIFO and HPB source models: pop on strobe, release HPB on clear.
  always @(negedge clk) begin
    if (fifo_ren) begin
      chk1("pop_nonempty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) begin
        fifo_rdata = fifo_q.pop_front();
        pops++;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    if (hpb_clr) begin
      hpb_valid = 1'b0;
      hpb_data  = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Transmitter responder: random events, predicts outcome from retry rules.
  always @(negedge clk) begin
    tx_done = 1'b0; tx_err = 1'b0; tx_arb = 1'b0; abort_l = 1'b0;
    fe = 1'b0;
    if (!resp_en) begin
      in_bo = 1'b0;
      fails = 0;
    end else if (in_bo) begin
      in_bo = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        abort_l = 1'b1;
        out_q.push_back(1'b0);
        fails = 0;
      end
    end else if (tx_req) begin
      // Scramble the HPB contents while a message is in flight.
      if (hpb_valid && $urandom_range(0, 1) == 1)
        hpb_data = {$urandom, $urandom, $urandom, $urandom};
      rsel = int'($urandom_range(0, 9));
      case (rsel)
        2, 3: begin tx_done = 1'b1; out_q.push_back(1'b1); fails = 0; end
        4: begin
          tx_done = 1'b1; tx_err = 1'b1; abort_l = 1'($urandom_range(0, 1));
          out_q.push_back(1'b1); fails = 0;
        end
        5: begin tx_err = 1'b1; fe = 1'b1; end
        6: begin tx_arb = 1'b1; fe = 1'b1; end
        7: begin tx_err = 1'b1; tx_arb = 1'b1; fe = 1'b1; end
        8: begin abort_l = 1'b1; out_q.push_back(1'b0); fails = 0; end
        9: begin tx_err = 1'b1; abort_l = 1'b1; fe = 1'b1; end
        default: ;
      endcase
      if (fe) begin
        fails++;
        if (fails == MAX_RETRY) begin
          out_q.push_back(1'b0);
          fails = 0;
        end else begin
          in_bo = 1'b1;
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      // Stray pulses outside REQUEST must be ignored.
      case ($urandom_range(0, 2))
        0: tx_done = 1'b1;
        1: tx_err  = 1'b1;
        default: tx_arb = 1'b1;
      endcase
    end
  end

  // Monitor: message stability during REQUEST and end-of-message scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_req && exp_q.size() > 0)
        chk128("msg_stable", tx_msg, exp_q[0].data);
      if (tx_ok || tx_fail) begin
        if (exp_q.size() == 0 || out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: ok=%b fail=%b with no pending expectation", tx_ok, tx_fail);
        end else begin
          exp_t e;
          bit   o;
          e = exp_q.pop_front();
          o = out_q.pop_front();
          chk1("outcome_ok", tx_ok, o);
          chk1("outcome_fail", tx_fail, !o);
          chk128("end_msg", tx_msg, e.data);
          chk1("hpb_clr", hpb_clr, e.hpb);
          chk1("req_low_at_end", tx_req, 1'b0);
        end
      end else if (hpb_clr) begin
        checks++; errors++;
        $display("FAIL stray_hpb_clr: got 1 expected 0 at %0t", $time);
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0 && out_q.size() == 0 && !txbsy && !hpb_valid && fifo_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for idle, pending=%0d busy=%b", nm, exp_q.size(), txbsy);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_ren"}, fifo_ren, 1'b0);
    chk1({nm, "_clr"}, hpb_clr, 1'b0);
    chk1({nm, "_req"}, tx_req, 1'b0);
    chk1({nm, "_bsy"}, txbsy, 1'b0);
    chk1({nm, "_ok"}, tx_ok, 1'b0);
    chk1({nm, "_fail"}, tx_fail, 1'b0);
    chk128({nm, "_msg"}, tx_msg, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, first;
    int  nf;
    bit  use_hpb;
    rst = 1'b1; fifo_empty = 1'b1; fifo_rdata = '0;
    hpb_valid = 1'b0; hpb_data = '0;
    tx_done = 1'b0; tx_err = 1'b0; tx_arb = 1'b0; abort_l = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    resp_en = 1'b1;

    for (int r = 0; r < 40; r++) begin
      wait_idle("round_idle");
      if (r == 0) begin
        nf = 1; use_hpb = 1'b0;
      end else if (r == 1) begin
        nf = 1; use_hpb = 1'b1;
      end else begin
        nf = int'($urandom_range(0, 3));
        use_hpb = 1'($urandom_range(0, 1));
        if (nf == 0) use_hpb = 1'b1;
      end
      if (use_hpb) begin
        hpb_data  = {$urandom, $urandom, $urandom, $urandom};
        hpb_valid = 1'b1;
        exp_q.push_back('{data: hpb_data, hpb: 1'b1});
      end
      for (int k = 0; k < nf; k++) begin
        if (r == 0) d = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_00000001;
        else        d = {$urandom, $urandom, $urandom, $urandom};
        fifo_q.push_back(d);
        exp_q.push_back('{data: d, hpb: 1'b0});
        pushes++;
      end
      fifo_empty = (fifo_q.size() == 0);
      first = exp_q[0].data;
      // Source seen in IDLE this cycle: pop at +1, request at +3.
      @(negedge clk);
      chk1("lat_ren", fifo_ren, !use_hpb);
      chk1("lat_bsy", txbsy, 1'b1);
      @(negedge clk);
      chk1("lat_ren_off", fifo_ren, 1'b0);
      chk1("lat_req_early", tx_req, 1'b0);
      @(negedge clk);
      chk1("lat_req", tx_req, 1'b1);
      chk128("lat_msg", tx_msg, first);
    end
    wait_idle("final_idle");
    chkint("pop_count", pops, pushes);

    // Reset mid-REQUEST: message lost silently, HPB kept, then resent.
    resp_en = 1'b0;
    hpb_data  = {$urandom, $urandom, $urandom, $urandom};
    hpb_valid = 1'b1;
    exp_q.push_back('{data: hpb_data, hpb: 1'b1});
    for (int t = 0; t < 20 && !tx_req; t++) @(negedge clk);
    chk1("rst_test_req", tx_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    resp_en = 1'b1;
    chk1("hpb_kept", hpb_valid, 1'b1);
    @(negedge clk);
    chk1("post_rst_bsy", txbsy, 1'b1);
    chk1("post_rst_ok", tx_ok, 1'b0);
    chk1("post_rst_fail", tx_fail, 1'b0);
    chk1("post_rst_clr", hpb_clr, 1'b0);
    wait_idle("resend_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
